// File: rtl/uart_pkg.sv
// Shared UART definitions.
//   uart_arb_state_t : states of the transmitter-sharing arbiter FSM
//   UART_DATA_WIDTH  : default byte width for UART datapaths
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } uart_arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker.
// Searches upward from last+1 (wrapping modulo NUM_REQ) for the first set
// bit of req.
//   req   in  NUM_REQ          request vector
//   last  in  $clog2(NUM_REQ)  index granted most recently
//   grant out NUM_REQ          one-hot winner (all-zero when none)
//   index out $clog2(NUM_REQ)  winner index (0 when none)
//   any   out 1                at least one request present
module rr_priority_picker #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] index,
    output logic                       any
);

    localparam int IDX_W = $clog2(NUM_REQ);

    int pos;

    // Walk offsets from the farthest to the nearest so that the nearest
    // requester after 'last' is the one left standing.
    always_comb begin
        pos   = 0;
        index = '0;
        any   = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            pos = (int'(last) + k) % NUM_REQ;
            if (req[IDX_W'(pos)]) begin
                index = IDX_W'(pos);
                any   = 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
            assign grant[gi] = any && (index == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte
// requesters. One byte is accepted per frame; the transmitter busy flag is
// tracked until the frame ends, with a timeout if busy never rises.
//   clk           in   system clock
//   rst           in   asynchronous active-high reset
//   req_valid     in   per-requester byte-offered flags
//   req_data      in   packed bytes, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready     out  one-hot accept (only in IDLE with transmitter idle)
//   tx_start      out  one-cycle frame launch pulse
//   tx_data       out  byte for the transmitter, stable for the whole frame
//   tx_busy       in   transmitter frame-in-progress flag
//   grant_id      out  requester owning the current/last frame
//   start_timeout out  one-cycle pulse: busy never rose after tx_start
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = UART_DATA_WIDTH,
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          tx_start,
    output logic [DATA_WIDTH-1:0]         tx_data,
    input  logic                          tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          start_timeout
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BUSY_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUSY_TIMEOUT - 1);

    uart_arb_state_t  state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [IDX_W-1:0] last_grant_reg;

    logic [NUM_REQ-1:0]    pick_grant;
    logic [IDX_W-1:0]      pick_index;
    logic                  pick_any;
    logic                  accept;
    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req   (req_valid),
        .last  (last_grant_reg),
        .grant (pick_grant),
        .index (pick_index),
        .any   (pick_any)
    );

    // A busy transmitter in IDLE belongs to someone else (or is a stale
    // frame from before reset), so nothing is accepted until it clears.
    assign accept    = (state_reg == IDLE) && !tx_busy && pick_any;
    assign req_ready = (accept && !rst) ? pick_grant : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            last_grant_reg <= IDX_W'(NUM_REQ - 1);
            tx_data        <= '0;
            grant_id       <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                tx_data        <= data_arr[pick_index];
                grant_id       <= pick_index;
                last_grant_reg <= pick_index;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        tx_start      = 1'b0;
        start_timeout = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) state_next = START;
            end
            START: begin
                // Busy seen here is ignored; WAIT_BUSY samples it next.
                tx_start   = 1'b1;
                cnt_next   = '0;
                state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // Busy wins over an expiring count on the same edge.
                if (tx_busy) begin
                    state_next = WAIT_DONE;
                end else if (cnt_reg == CNT_MAX) begin
                    start_timeout = 1'b1;
                    state_next    = IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus pushes the expected frame
// (byte, grant) per accept; a monitor pops and compares on every tx_start.
module tb_uart_tx_arbiter;

    localparam int DW    = 8;
    localparam int NR    = 4;
    localparam int TO    = 16;
    localparam int FRAME = 40;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              tx_start;
    logic [DW-1:0]     tx_data;
    logic              tx_busy;
    logic [1:0]        grant_id;
    logic              start_timeout;

    logic model_busy = 1'b0;
    logic force_busy = 1'b0;
    assign tx_busy = model_busy | force_busy;

    uart_tx_arbiter #(
        .DATA_WIDTH   (DW),
        .NUM_REQ      (NR),
        .BUSY_TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .tx_start      (tx_start),
        .tx_data       (tx_data),
        .tx_busy       (tx_busy),
        .grant_id      (grant_id),
        .start_timeout (start_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic [1:0] gid;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   pass_cnt    = 0;
    int   total_cnt   = 0;
    int   pushed      = 0;
    int   start_cnt   = 0;
    int   to_expected = 0;
    int   to_seen     = 0;
    int   mode        = 0;   // 0: transmitter answers, 1: never raises busy
    bit   chk_gap     = 1'b0;
    bit   prev_busy   = 1'b0;
    int   fall_cyc    = 0;
    int   start_cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic push(input logic [7:0] d, input logic [1:0] g);
        exp_t x;
        x.data = d;
        x.gid  = g;
        exp_q.push_back(x);
        pushed++;
    endtask

    task automatic drive(input logic [NR-1:0] v);
        @(posedge clk);
        #1 req_valid = v;
    endtask

    task automatic wait_starts(input int target);
        int n = 0;
        while (start_cnt < target && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("start_wait", start_cnt, target);
    endtask

    task automatic wait_idle();
        int n = 0;
        repeat (4) @(negedge clk);
        while (tx_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("busy_fall_wait", tx_busy, 0);
        repeat (2) @(negedge clk);
    endtask

    // Transmitter model: busy rises two cycles after a start, lasts FRAME.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start && mode == 0) begin
                repeat (2) @(posedge clk);
                #1 model_busy = 1'b1;
                repeat (FRAME) @(posedge clk);
                #1 model_busy = 1'b0;
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (prev_busy && !tx_busy) fall_cyc = cyc;
            prev_busy = tx_busy;
            if (tx_start) begin
                start_cnt++;
                start_cyc = cyc;
                check("start_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    $display("frame %0d: grant_id=%0d tx_data=%02h (cycle %0d)",
                             start_cnt, grant_id, tx_data, cyc);
                    check("tx_data", tx_data, e.data);
                    check("grant_id", grant_id, e.gid);
                end
                if (chk_gap) check("start_gap", cyc - fall_cyc, 2);
            end
            if (start_timeout) begin
                to_seen++;
                $display("timeout %0d: %0d cycles after tx_start", to_seen, cyc - start_cyc);
                check("timeout_expected", to_seen <= to_expected, 1);
                check("timeout_delay", cyc - start_cyc, TO);
            end
        end
    end

    initial begin
        int n;
        // Reset state, with all requesters valid to show ready is held off.
        rst       = 1'b1;
        req_valid = 4'b1111;
        req_data  = 32'h44332211;
        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_start_timeout", start_timeout, 0);
        @(posedge clk);
        #1 req_valid = '0;
        rst = 1'b0;

        // Single requester.
        req_data[7:0] = 8'hA5;
        push(8'hA5, 2'd0);
        drive(4'b0001);
        @(negedge clk);
        check("ready_single", req_ready, 4'b0001);
        drive(4'b0000);
        wait_starts(pushed);
        wait_idle();

        // All four valid after a fresh reset: 0,1,2,3,0 with 2-cycle turnaround.
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        req_data = 32'h44332211;
        push(8'h11, 2'd0);
        push(8'h22, 2'd1);
        push(8'h33, 2'd2);
        push(8'h44, 2'd3);
        push(8'h11, 2'd0);
        drive(4'b1111);
        wait_starts(pushed - 4);
        chk_gap = 1'b1;
        wait_starts(pushed);
        drive(4'b0000);
        chk_gap = 1'b0;
        wait_idle();

        // Requesters 2 and 3 withdraw after requester 1 is granted: wraps to 0.
        push(8'h22, 2'd1);
        push(8'h11, 2'd0);
        drive(4'b1111);
        wait_starts(pushed - 1);
        drive(4'b0011);
        wait_starts(pushed);
        drive(4'b0000);
        wait_idle();

        // Transmitter never answers: two timeouts, grant advances 1 -> 2.
        mode = 1;
        to_expected += 2;
        push(8'h22, 2'd1);
        push(8'h33, 2'd2);
        drive(4'b0110);
        wait_starts(pushed - 1);
        wait_starts(pushed);
        drive(4'b0000);
        n = 0;
        while (to_seen < to_expected && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("timeout_count", to_seen, to_expected);
        mode = 0;
        repeat (3) @(negedge clk);

        // Busy held high through reset release: no ready until it falls.
        @(posedge clk);
        #1 rst = 1'b1;
        force_busy = 1'b1;
        req_valid  = 4'b1111;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("ready_while_busy", req_ready, 0);
        end
        @(posedge clk);
        #1 force_busy = 1'b0;
        push(8'h11, 2'd0);
        @(negedge clk);
        check("ready_after_busy", req_ready, 4'b0001);
        drive(4'b0000);
        wait_starts(pushed);
        wait_idle();

        // Asynchronous reset while in WAIT_DONE.
        push(8'h33, 2'd2);
        drive(4'b0100);
        drive(4'b0000);
        wait_starts(pushed);
        repeat (6) @(negedge clk);
        check("busy_before_reset", tx_busy, 1);
        @(posedge clk);
        #3 rst = 1'b1;
        req_valid = 4'b1111;
        #1;
        check("async_rst_tx_data", tx_data, 0);
        check("async_rst_grant_id", grant_id, 0);
        check("async_rst_req_ready", req_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        push(8'h11, 2'd0);
        @(negedge clk);
        check("ready_stale_busy", req_ready, 0);
        wait_starts(pushed);
        drive(4'b0000);
        wait_idle();

        check("scoreboard_empty", exp_q.size(), 0);
        check("timeouts_total", to_seen, to_expected);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
